// File: rtl/abc_tx.sv
// Two-lane LSB-first serial transmitter: accepts a word pair over valid/ready,
// shifts it out on data1/data2 framed by `frame`, then idles GAP_CYCLES cycles.
module abc_tx #(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data1,
   input  logic [WIDTH-1:0] in_data2,
   output logic             data1,
   output logic             data2,
   output logic             frame,
   output logic             done
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [3:0]       gap_cnt;
   logic [WIDTH-1:0] sh1;
   logic [WIDTH-1:0] sh2;
   logic             last;
   logic             accept;

   // in_ready depends only on state/counter so upstream can never form a loop through it.
   assign last     = (state == SHIFT) && (cnt == CNT_LAST);
   assign in_ready = (state == IDLE) || (last && GAP_CYCLES == 0);
   assign done     = last;
   assign accept   = in_valid && in_ready;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values and the order of statements does not matter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         gap_cnt <= '0;
         sh1     <= '0;
         sh2     <= '0;
         data1   <= 1'b0;
         data2   <= 1'b0;
         frame   <= 1'b0;
      end else if (accept) begin
         // Bit 0 goes straight to the lines; the shifters hold the remaining bits.
         sh1   <= in_data1 >> 1;
         sh2   <= in_data2 >> 1;
         data1 <= in_data1[0];
         data2 <= in_data2[0];
         frame <= 1'b1;
         cnt   <= '0;
         state <= SHIFT;
      end else begin
         unique case (state)
            IDLE: begin
               data1 <= 1'b0;
               data2 <= 1'b0;
               frame <= 1'b0;
            end
            SHIFT: begin
               if (cnt != CNT_LAST) begin
                  cnt   <= cnt + 1'b1;
                  data1 <= sh1[0];
                  data2 <= sh2[0];
                  sh1   <= sh1 >> 1;
                  sh2   <= sh2 >> 1;
               end else begin
                  data1 <= 1'b0;
                  data2 <= 1'b0;
                  frame <= 1'b0;
                  if (GAP_CYCLES > 0) begin
                     state   <= GAP;
                     gap_cnt <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt + 1'b1;
               if (gap_cnt == GAP_LAST) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
